// File: rtl/freq_meas_pkg.sv
// Shared types for the reciprocal frequency meter.
// State encoding, MCU byte selects, result byte mux.
package freq_meas_pkg;

  localparam int DEF_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    GATE,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    SEL_FX_B0,
    SEL_FX_B1,
    SEL_FX_B2,
    SEL_FX_B3,
    SEL_BASE_B0,
    SEL_BASE_B1,
    SEL_BASE_B2,
    SEL_BASE_B3
  } sel_t;

  function automatic logic [7:0] pick_byte(
    input logic [2:0]  sel,
    input logic [31:0] f,
    input logic [31:0] b
  );
    logic [7:0] r;
    r = '0;
    case (sel_t'(sel))
      SEL_FX_B0:   r = f[7:0];
      SEL_FX_B1:   r = f[15:8];
      SEL_FX_B2:   r = f[23:16];
      SEL_FX_B3:   r = f[31:24];
      SEL_BASE_B0: r = b[7:0];
      SEL_BASE_B1: r = b[15:8];
      SEL_BASE_B2: r = b[23:16];
      SEL_BASE_B3: r = b[31:24];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/freq_gate_ctrl_if.sv
// MCU-side handshake and byte read port.
// master = MCU, slave = measurement sequencer.
interface freq_gate_ctrl_if;
  logic       start;
  logic [2:0] sel;
  logic       ack;
  logic [7:0] data_out;
  logic       data_ready;
  logic       timeout;
  logic       busy;
  logic       gate;

  modport master (
    output start, sel, ack,
    input  data_out, data_ready, timeout, busy, gate
  );

  modport slave (
    input  start, sel, ack,
    output data_out, data_ready, timeout, busy, gate
  );
endinterface

// File: rtl/fx_edge_sync.sv
// 2-FF synchroniser plus registered rising-edge pulse.
// A rise is only reported after a real low sample.
module fx_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [1:0] sync;
  logic [1:0] vld;
  logic       prev;
  logic       lo_seen;

  // sync[1] carries a genuine pin sample once vld[1] is set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      vld     <= '0;
      prev    <= 1'b0;
      lo_seen <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync    <= {sync[0], d};
      vld     <= {vld[0], 1'b1};
      prev    <= sync[1];
      lo_seen <= lo_seen | (vld[1] & ~sync[1]);
      rise    <= sync[1] & ~prev & lo_seen;
    end
  end

endmodule

// File: rtl/freq_gate_ctrl.sv
// Equal-precision gate sequencer: gate opens and
// closes on fx edges, counts fx and sysclk inside it.
module freq_gate_ctrl
  import freq_meas_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int GATE_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int CONTINUOUS     = 0
) (
  input logic              sysclk,
  input logic              reset,
  input logic              fx,
  freq_gate_ctrl_if.slave  bus
);

  localparam logic [31:0] TO_LIM =
    32'(TIMEOUT_CYCLES);
  localparam logic [31:0] GATE_LIM =
    32'(GATE_CYCLES);
  localparam logic [31:0] ABORT_LIM =
    32'(GATE_CYCLES + TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic             fx_rise;
  logic [CNT_W-1:0] fx_cnt, base_cnt;
  logic [CNT_W-1:0] fx_nxt, base_nxt;
  logic [CNT_W-1:0] res_fx, res_base;
  logic [31:0]      timer, timer_nxt;
  logic             to_flag;
  logic             start_go;
  logic             arm_go, arm_to;
  logic             gate_close, gate_to;

  fx_edge_sync u_sync (
    .clk   (sysclk),
    .rst_n (reset),
    .d     (fx),
    .rise  (fx_rise)
  );

  assign timer_nxt = timer + 32'd1;
  assign fx_nxt = (fx_rise && fx_cnt != '1)
                ? fx_cnt + ONE : fx_cnt;
  assign base_nxt = (base_cnt != '1)
                  ? base_cnt + ONE : base_cnt;

  assign start_go = bus.start | (CONTINUOUS != 0);
  assign arm_go = (state == ARM) & fx_rise;
  assign arm_to = (state == ARM) & ~fx_rise
                & (timer_nxt >= TO_LIM);
  assign gate_close = (state == GATE) & fx_rise
                    & (timer_nxt >= GATE_LIM);
  assign gate_to = (state == GATE) & ~gate_close
                 & (timer_nxt >= ABORT_LIM);

  // state register
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start_go) state_nxt = ARM;
      ARM: begin
        if (arm_go)      state_nxt = GATE;
        else if (arm_to) state_nxt = DONE;
      end
      GATE: if (gate_close | gate_to) state_nxt = DONE;
      DONE: begin
        if (bus.ack)
          state_nxt = (CONTINUOUS != 0) ? ARM : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // status outputs decoded from state
  always_comb begin
    bus.busy       = (state == ARM) | (state == GATE);
    bus.gate       = (state == GATE);
    bus.data_ready = (state == DONE);
    bus.timeout    = to_flag;
  end

  // counters, timer, result latch and timeout flag
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      fx_cnt   <= '0;
      base_cnt <= '0;
      res_fx   <= '0;
      res_base <= '0;
      timer    <= '0;
      to_flag  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          timer <= '0;
          if (start_go) to_flag <= 1'b0;
        end
        ARM: begin
          if (arm_go) begin
            fx_cnt   <= '0;
            base_cnt <= '0;
            timer    <= '0;
          end else if (arm_to) begin
            res_fx   <= '0;
            res_base <= '0;
            to_flag  <= 1'b1;
          end else begin
            timer <= timer_nxt;
          end
        end
        GATE: begin
          fx_cnt   <= fx_nxt;
          base_cnt <= base_nxt;
          timer    <= timer_nxt;
          if (gate_close) begin
            res_fx   <= fx_nxt;
            res_base <= base_nxt;
          end else if (gate_to) begin
            res_fx   <= '0;
            res_base <= '0;
            to_flag  <= 1'b1;
          end
        end
        DONE: begin
          if (bus.ack) begin
            timer <= '0;
            if (CONTINUOUS != 0) to_flag <= 1'b0;
          end
        end
        default: timer <= '0;
      endcase
    end
  end

  // registered byte read of the latched results
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) bus.data_out <= '0;
    else bus.data_out <= pick_byte(bus.sel,
                           32'(res_fx), 32'(res_base));
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Bench for freq_gate_ctrl: vector table plus
// hand sequences, results via scoreboard queue.
module tb_freq_gate_ctrl;

  localparam int GC  = 1000;
  localparam int TOC = 500;
  localparam int LIM = 4000;

  typedef struct {
    int          per;
    logic [31:0] efx;
    logic [31:0] ebase;
    logic        eto;
  } vec_t;

  typedef struct {
    logic [31:0] fx;
    logic [31:0] base;
    logic        to;
  } res_t;

  logic sysclk = 0;
  logic rst0 = 0;
  logic rst1 = 0;
  logic fx0 = 0;
  logic fx1 = 0;
  int   per0 = 10;
  int   per1 = 20;
  int   n_chk = 0;
  int   n_fail = 0;
  res_t sb[$];
  vec_t vecs[5];

  freq_gate_ctrl_if if0 ();
  freq_gate_ctrl_if if1 ();

  freq_gate_ctrl #(
    .CNT_W(32), .GATE_CYCLES(GC),
    .TIMEOUT_CYCLES(TOC), .CONTINUOUS(0)
  ) u0 (
    .sysclk(sysclk), .reset(rst0),
    .fx(fx0), .bus(if0)
  );

  freq_gate_ctrl #(
    .CNT_W(32), .GATE_CYCLES(GC),
    .TIMEOUT_CYCLES(TOC), .CONTINUOUS(1)
  ) u1 (
    .sysclk(sysclk), .reset(rst1),
    .fx(fx1), .bus(if1)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    forever begin
      if (per0 == 0) begin
        fx0 = 0;
        @(posedge sysclk); #3;
      end else begin
        fx0 = 1;
        repeat (per0 / 2) @(posedge sysclk);
        #3; fx0 = 0;
        repeat (per0 - per0 / 2) @(posedge sysclk);
        #3;
      end
    end
  end

  initial begin
    forever begin
      fx1 = 1;
      repeat (per1 / 2) @(posedge sysclk);
      #3; fx1 = 0;
      repeat (per1 - per1 / 2) @(posedge sysclk);
      #3;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: sim time %0t limit 3ms", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk); #1;
  endtask

  task automatic rd(input int k,
                    output logic [31:0] f,
                    output logic [31:0] b);
    logic [7:0] byt;
    for (int i = 0; i < 8; i++) begin
      if (k == 0) if0.sel = 3'(i);
      else        if1.sel = 3'(i);
      tick();
      byt = (k == 0) ? if0.data_out : if1.data_out;
      if (i < 4) f[i*8 +: 8] = byt;
      else       b[(i-4)*8 +: 8] = byt;
    end
  endtask

  task automatic wait_ready(input int k, output int cyc);
    cyc = 0;
    while (((k == 0) ? if0.data_ready : if1.data_ready)
           !== 1'b1 && cyc < LIM) begin
      tick();
      cyc++;
    end
    chk("ready_in_time",
        (k == 0) ? if0.data_ready : if1.data_ready, 1);
  endtask

  task automatic check_result(input int k, input string nm);
    res_t e;
    logic [31:0] f, b;
    logic        to;
    to = (k == 0) ? if0.timeout : if1.timeout;
    rd(k, f, b);
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({nm, "_fx"}, f, e.fx);
      chk({nm, "_base"}, b, e.base);
      chk({nm, "_timeout"}, to, e.to);
    end
  endtask

  task automatic pulse_start0();
    if0.start = 1; tick(); if0.start = 0;
  endtask

  task automatic pulse_ack0();
    if0.ack = 1; tick(); if0.ack = 0;
  endtask

  task automatic settle0(input int p);
    per0 = p;
    repeat (3 * p + 12) tick();
  endtask

  task automatic run_meas(input vec_t v, input string nm);
    int cyc;
    settle0(v.per);
    pulse_start0();
    sb.push_back('{v.efx, v.ebase, v.eto});
    wait_ready(0, cyc);
    if (v.eto) chk({nm, "_to_latency"}, cyc, TOC);
    chk({nm, "_busy_gate_done"},
        {if0.busy, if0.gate}, 0);
    check_result(0, nm);
    pulse_ack0();
    chk({nm, "_ready_clr"}, if0.data_ready, 0);
  endtask

  task automatic wait_gate0(input string nm);
    int c;
    c = 0;
    while (if0.gate !== 1'b1 && c < LIM) begin
      tick(); c++;
    end
    chk({nm, "_gate_open"}, if0.gate, 1);
  endtask

  initial begin
    int cyc;
    logic [31:0] f, b;
    vecs[0] = '{10, 100, 1000, 0};
    vecs[1] = '{7, 143, 1001, 0};
    vecs[2] = '{0, 0, 0, 1};
    vecs[3] = '{13, 77, 1001, 0};
    vecs[4] = '{4, 250, 1000, 0};
    if0.start = 0; if0.sel = 0; if0.ack = 0;
    if1.start = 0; if1.sel = 0; if1.ack = 0;

    repeat (4) tick();
    chk("reset_outs",
        {if0.data_out, if0.data_ready, if0.timeout,
         if0.busy, if0.gate}, 0);
    rst0 = 1;
    tick();
    chk("idle_after_reset",
        {if0.busy, if0.gate, if0.data_ready}, 0);

    foreach (vecs[i])
      run_meas(vecs[i], $sformatf("vec%0d", i));

    // ack and start pulsed while the gate is open
    settle0(10);
    pulse_start0();
    sb.push_back('{32'd100, 32'd1000, 1'b0});
    wait_gate0("t6");
    repeat (100) tick();
    pulse_ack0();
    pulse_start0();
    chk("t6_still_gating", {if0.busy, if0.gate}, 2'b11);
    wait_ready(0, cyc);
    check_result(0, "t6");
    if0.sel = 3'd4; tick();
    chk("t6_sel4", if0.data_out, 8'hE8);
    if0.sel = 3'd5; #3;
    chk("t6_sel_latency", if0.data_out, 8'hE8);
    tick();
    chk("t6_sel5", if0.data_out, 8'h03);
    pulse_start0();
    chk("t6_start_in_done", if0.data_ready, 1);
    pulse_ack0();
    tick();
    chk("t6_back_idle",
        {if0.busy, if0.data_ready}, 0);

    // asynchronous reset in the middle of a gate
    settle0(10);
    pulse_start0();
    wait_gate0("t5");
    repeat (300) @(posedge sysclk);
    #2 rst0 = 0;
    #1;
    chk("t5_async_reset",
        {if0.data_out, if0.data_ready, if0.timeout,
         if0.busy, if0.gate}, 0);
    repeat (3) tick();
    rst0 = 1;
    rd(0, f, b);
    chk("t5_res_cleared", {f, b}, 0);
    run_meas('{10, 100, 1000, 0}, "t5_fresh");

    // continuous mode re-arms after ack
    rst1 = 1;
    sb.push_back('{32'd50, 32'd1000, 1'b0});
    repeat (50) tick();
    if1.start = 1; tick(); if1.start = 0;
    wait_ready(1, cyc);
    check_result(1, "cont1");
    if1.start = 1; tick(); if1.start = 0;
    chk("cont_start_ignored", if1.data_ready, 1);
    if1.ack = 1; tick(); if1.ack = 0;
    chk("cont_rearm", {if1.busy, if1.data_ready}, 2'b10);
    sb.push_back('{32'd50, 32'd1000, 1'b0});
    wait_ready(1, cyc);
    check_result(1, "cont2");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
